rgb2hsv_share_sched: RTL and testbench
======================================

# rgb2hsv_share_sched

Per-pixel scheduler that shares one fixed-latency, non-stallable RGB-to-HSV converter between two RGB pixel streams (the long- and short-exposure channels of the HDR path). It arbitrates the two valid/ready inputs onto the converter's r/g/b ports and tracks each issued pixel's source and sideband through a tag pipeline matched to the converter latency. Returned H/S/V results land in an output FIFO, and the block applies credit-based backpressure so no result is ever lost. It sits between the two camera-side pixel streams and the HDR merge logic.

## Interface
- PIPE_LAT, 17, converter latency in cycles from r/g/b sample edge to valid H/S/V (≥2)
- FIFO_DEPTH, 32, output FIFO entries (power of 2, ≥ PIPE_LAT+1)
- clk  in  1  sole clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- prio_mode  in  1  0 = round-robin, 1 = channel 0 strict priority
- in0_valid / in1_valid  in  1  channel pixel valid
- in0_ready / in1_ready  out  1  channel pixel accepted this cycle
- in0_rgb / in1_rgb  in  24  {r[23:16], g[15:8], b[7:0]}
- in0_sof, in0_eol / in1_sof, in1_eol  in  1  start-of-frame / end-of-line markers
- cv_r, cv_g, cv_b  out  8 each  to converter inputs
- cv_h  in  9; cv_s  in  11; cv_v  in  8  converter outputs
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_src  out  1  source channel of head pixel
- out_sof, out_eol  out  1  sideband of head pixel
- out_hsv  out  28  {h[27:19], s[18:8], v[7:0]}
- err_ovf  out  1  sticky: result returned while FIFO full (must never assert)

## Operation
- Issue condition: credits = FIFO_DEPTH − fifo_count − inflight, all values registered; issue is permitted only when credits > 0.
- Arbitration, round-robin: the last-granted pointer (`last`) alternates priority. With both inputs valid, the channel ≠ last wins. With one input valid, that channel wins.
- Arbitration, prio_mode=1: channel 0 always wins when valid. `last` still updates.
- ready: inN_ready = issue permitted && granted == N. Ready is combinational from the valids and registered state. A ready never depends on the same-cycle value of inN_ready.
- Issue: in the cycle where valid && ready are both high, cv_r/g/b register the granted rgb. The tag {1, src, sof, eol} enters stage 0 of a PIPE_LAT-deep shift register. A non-issue cycle shifts in tag valid = 0, and cv_r/g/b hold their previous value.
- inflight: +1 on issue, −1 when a valid tag exits, unchanged when both happen.
- Return: when a valid tag exits, push {tag.src, tag.sof, tag.eol, cv_h, cv_s, cv_v} into the FIFO on that edge. If the FIFO is full at that moment, set err_ovf, drop the pixel and keep the count unchanged.
- FIFO: first-word-fall-through. Pop on out_valid && out_ready. Simultaneous push and pop leave fifo_count unchanged. Pop when empty and push when full are ignored.
- Order: output order equals issue order. Per-channel ordering is preserved.

## Timing
- Reset values: in0_ready = in1_ready = 0, cv_r/g/b = 0, all tag stages invalid, inflight = 0, FIFO empty, out_valid = 0, out_src/sof/eol/hsv = 0, err_ovf = 0, last = 1 (so ch0 wins first).
- Issue edge T: cv_r/g/b change at T. The matching result is pushed at edge T+PIPE_LAT. out_valid rises at T+PIPE_LAT if the FIFO was empty (FWFT, 0 extra cycles).
- Maximum throughput is 1 pixel/clk aggregate. In round-robin with both channels saturated, grants alternate exactly: 0, 1, 0, 1, …
- Credit release: a pop at edge P raises credits from edge P onward, so issue can resume in the cycle after P.
- Reset asserted mid-operation: all in-flight tags and FIFO contents are discarded immediately. Converter results arriving afterwards are ignored because their tags are invalid.

## Structure
- Package rgb2hsv_sched_pkg:
  - hsv_tag_t {valid, src, sof, eol}
  - hsv_pix_t {src, sof, eol, h[8:0], s[10:0], v[7:0]}
  - localparam HSV_W = 28
- Sub-module: hsv_fifo, a parameterised FWFT synchronous FIFO of hsv_pix_t with count output.
- Arbiter, tag pipe and credit counter live in the top module.

## Test plan
- Reset release, no input → all outputs 0. First in0 pixel rgb = FF0000, sof = 1, issued at cycle T → out_hsv = {0, 2047, 255}, out_src = 0, out_sof = 1 at T+17.
- Both channels valid continuously, prio_mode = 0, out_ready = 1 → out_src sequence 0, 1, 0, 1, … with no bubbles after fill.
- prio_mode = 1, both valid for 10 cycles → 10 ch0 grants, in1_ready = 0 throughout.
- out_ready = 0, both valid → exactly FIFO_DEPTH pixels accepted in total. Ready deasserts once credits reach 0. err_ovf stays 0. Releasing out_ready drains 32 pixels in issue order.
- Single-cycle out_ready pulse with FIFO full → exactly one new issue on the next cycle.
- reset_b pulsed low with 5 pixels in flight → out_valid = 0 after release. No stale pixel appears 17 cycles later.

Source files
------------

// File: rtl/rgb2hsv_sched_pkg.sv
// Shared types for the RGB-to-HSV converter sharing scheduler: the tag that
// travels alongside the converter pipeline and the pixel stored in the output FIFO.
package rgb2hsv_sched_pkg;

    localparam int HSV_W = 28;

    typedef struct packed {
        logic valid;
        logic src;
        logic sof;
        logic eol;
    } hsv_tag_t;

    typedef struct packed {
        logic        src;
        logic        sof;
        logic        eol;
        logic [8:0]  h;
        logic [10:0] s;
        logic [7:0]  v;
    } hsv_pix_t;

    // Flatten the colour fields of a stored pixel into the {h, s, v} output word.
    function automatic logic [HSV_W-1:0] pack_hsv(input hsv_pix_t p);
        return {p.h, p.s, p.v};
    endfunction

endpackage

// File: rtl/hsv_fifo.sv
// First-word-fall-through FIFO of HSV pixels. The head is visible as soon as
// the first word is written; a pop on empty and a push on full are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module hsv_fifo
    import rgb2hsv_sched_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     push,
    input  hsv_pix_t                 push_data,
    input  logic                     pop,
    output hsv_pix_t                 head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    hsv_pix_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_V);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; left unreset because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rgb2hsv_share_sched.sv
// Shares one fixed-latency, non-stallable RGB-to-HSV converter between two pixel
// streams. A tag pipeline as deep as the converter remembers who issued each
// pixel; results land in an output FIFO. Issue is only allowed while the FIFO
// plus everything still inside the converter leaves room, so no result is lost.
module rgb2hsv_share_sched
    import rgb2hsv_sched_pkg::*;
#(
    parameter int PIPE_LAT   = 17,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              prio_mode,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [23:0]       in0_rgb,
    input  logic              in0_sof,
    input  logic              in0_eol,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [23:0]       in1_rgb,
    input  logic              in1_sof,
    input  logic              in1_eol,
    output logic [7:0]        cv_r,
    output logic [7:0]        cv_g,
    output logic [7:0]        cv_b,
    input  logic [8:0]        cv_h,
    input  logic [10:0]       cv_s,
    input  logic [7:0]        cv_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic              out_sof,
    output logic              out_eol,
    output logic [HSV_W-1:0]  out_hsv,
    output logic              err_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight;
    logic [CW:0]    used;
    logic           can_issue;
    logic           last;
    logic           grant_valid;
    logic           grant_src;
    logic           issue;
    logic [23:0]    issue_rgb;
    hsv_tag_t       new_tag;
    hsv_tag_t       tag_pipe [PIPE_LAT];
    hsv_tag_t       exit_tag;
    hsv_pix_t       ret_pix;
    hsv_pix_t       head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;

    // Credits are whatever the FIFO can still absorb once every in-flight pixel returns.
    assign used      = {1'b0, fifo_count} + {1'b0, inflight};
    assign can_issue = (used < DEPTH_EXT);

    // Pick a channel: strict ch0 priority, or alternate away from the last winner when both want in.
    always_comb begin
        grant_valid = in0_valid || in1_valid;
        grant_src   = 1'b0;
        if (in0_valid && in1_valid) begin
            grant_src = prio_mode ? 1'b0 : ~last;
        end else if (in1_valid) begin
            grant_src = 1'b1;
        end
    end

    assign issue     = can_issue && grant_valid;
    assign in0_ready = issue && !grant_src;
    assign in1_ready = issue && grant_src;

    // Build the tag that follows the granted pixel through the converter.
    always_comb begin
        issue_rgb = grant_src ? in1_rgb : in0_rgb;
        new_tag   = '0;
        if (issue) begin
            new_tag.valid = 1'b1;
            new_tag.src   = grant_src;
            new_tag.sof   = grant_src ? in1_sof : in0_sof;
            new_tag.eol   = grant_src ? in1_eol : in0_eol;
        end
    end

    // Drive the converter inputs on issue and remember the winner; idle cycles hold the last pixel.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cv_r <= '0;
            cv_g <= '0;
            cv_b <= '0;
            last <= 1'b1;
        end else if (issue) begin
            cv_r <= issue_rgb[23:16];
            cv_g <= issue_rgb[15:8];
            cv_b <= issue_rgb[7:0];
            last <= grant_src;
        end
    end

    // Tag shift register matched to the converter latency; a reset invalidates every pending result.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign exit_tag = tag_pipe[PIPE_LAT-1];

    // Count pixels currently inside the converter.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            inflight <= '0;
        end else begin
            case ({issue, exit_tag.valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Pair the converter outputs with the tag leaving the pipe this cycle.
    always_comb begin
        ret_pix     = '0;
        ret_pix.src = exit_tag.src;
        ret_pix.sof = exit_tag.sof;
        ret_pix.eol = exit_tag.eol;
        ret_pix.h   = cv_h;
        ret_pix.s   = cv_s;
        ret_pix.v   = cv_v;
    end

    assign pop = out_valid && out_ready;

    hsv_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_b   (reset_b),
        .push      (exit_tag.valid),
        .push_data (ret_pix),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Sticky flag for a result that arrived with nowhere to go; the credit scheme should keep it low.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_ovf <= 1'b0;
        end else if (exit_tag.valid && fifo_full) begin
            err_ovf <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_src   = head.src;
    assign out_sof   = head.sof;
    assign out_eol   = head.eol;
    assign out_hsv   = pack_hsv(head);

endmodule

// File: tb/tb_rgb2hsv_share_sched.sv
// Randomised self-checking bench for rgb2hsv_share_sched. The bench plays the
// converter and keeps a queue model of every issued-but-not-yet-popped pixel.
module tb_rgb2hsv_share_sched;

    localparam int PIPE_LAT   = 17;
    localparam int FIFO_DEPTH = 32;

    logic        clk;
    logic        reset_b;
    logic        prio_mode;
    logic        in0_valid, in0_ready, in0_sof, in0_eol;
    logic        in1_valid, in1_ready, in1_sof, in1_eol;
    logic [23:0] in0_rgb, in1_rgb;
    logic [7:0]  cv_r, cv_g, cv_b;
    logic [8:0]  cv_h;
    logic [10:0] cv_s;
    logic [7:0]  cv_v;
    logic        out_valid, out_ready, out_src, out_sof, out_eol, err_ovf;
    logic [27:0] out_hsv;

    typedef struct {
        int          t;
        logic        src;
        logic        sof;
        logic        eol;
        logic [27:0] hsv;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_last;
    logic [23:0] m_rgb;
    logic        acc0, acc1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_issue = 0;
    int          grants0 = 0;
    int          grants1 = 0;
    int          in1_ready_hi = 0;
    int          last_issue_t = 0;
    int          stale = 0;
    bit          auto_in = 0;
    bit          auto_rdy = 0;
    int          p0 = 0, p1 = 0, rdy_pct = 100;
    logic [23:0] conv_pipe [PIPE_LAT-1];

    rgb2hsv_share_sched #(
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .prio_mode (prio_mode),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_rgb   (in0_rgb),
        .in0_sof   (in0_sof),
        .in0_eol   (in0_eol),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_rgb   (in1_rgb),
        .in1_sof   (in1_sof),
        .in1_eol   (in1_eol),
        .cv_r      (cv_r),
        .cv_g      (cv_g),
        .cv_b      (cv_b),
        .cv_h      (cv_h),
        .cv_s      (cv_s),
        .cv_v      (cv_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_hsv   (out_hsv),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference RGB-to-HSV conversion: hue in degrees, saturation scaled to 2047, value = max.
    function automatic logic [27:0] hsv_of(input logic [23:0] rgb);
        int r, g, b, mx, mn, d, h, s;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        mx = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
        mn = (r < g) ? ((r < b) ? r : b) : ((g < b) ? g : b);
        d  = mx - mn;
        if (d == 0) h = 0;
        else if (mx == r) begin
            h = (60 * (g - b)) / d;
            if (h < 0) h = h + 360;
        end
        else if (mx == g) h = 120 + (60 * (b - r)) / d;
        else h = 240 + (60 * (r - g)) / d;
        s = (mx == 0) ? 0 : (d * 2047) / mx;
        return {9'(h), 11'(s), 8'(mx)};
    endfunction

    // Converter stand-in: the pixel on cv_r/g/b after issue edge T is presented on cv_h/s/v
    // during the cycle that ends with edge T+PIPE_LAT.
    always @(posedge clk) begin
        conv_pipe[0] <= {cv_r, cv_g, cv_b};
        for (int i = 1; i < PIPE_LAT - 1; i++) conv_pipe[i] <= conv_pipe[i-1];
    end
    assign {cv_h, cv_s, cv_v} = hsv_of(conv_pipe[PIPE_LAT-2]);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model and compare: pixels leave in issue order PIPE_LAT cycles after issue at the earliest,
    // and issue is allowed only while fewer than FIFO_DEPTH pixels are outstanding.
    always @(negedge clk) begin : cmp
        logic gv, gs, e0, e1, hv;
        exp_t it;
        if (!reset_b) begin
            exp_q.delete();
            m_last = 1'b1;
            m_rgb  = '0;
            acc0   = 1'b0;
            acc1   = 1'b0;
            checkOutput("rst_in0_ready", 32'(in0_ready), 0);
            checkOutput("rst_in1_ready", 32'(in1_ready), 0);
            checkOutput("rst_out_valid", 32'(out_valid), 0);
            checkOutput("rst_cv_rgb", {8'd0, cv_r, cv_g, cv_b}, 0);
            checkOutput("rst_out_hsv", 32'(out_hsv), 0);
            checkOutput("rst_out_side", {29'd0, out_src, out_sof, out_eol}, 0);
            checkOutput("rst_err_ovf", 32'(err_ovf), 0);
        end else begin
            gv = in0_valid || in1_valid;
            if (in0_valid && in1_valid) gs = prio_mode ? 1'b0 : !m_last;
            else gs = in1_valid;
            e0 = gv && !gs && (exp_q.size() < FIFO_DEPTH);
            e1 = gv && gs && (exp_q.size() < FIFO_DEPTH);
            checkOutput("in0_ready", 32'(in0_ready), 32'(e0));
            checkOutput("in1_ready", 32'(in1_ready), 32'(e1));
            checkOutput("cv_rgb", {8'd0, cv_r, cv_g, cv_b}, {8'd0, m_rgb});
            hv = (exp_q.size() > 0) && (cyc >= exp_q[0].t + PIPE_LAT);
            checkOutput("out_valid", 32'(out_valid), 32'(hv));
            if (hv) begin
                checkOutput("out_src", 32'(out_src), 32'(exp_q[0].src));
                checkOutput("out_sof", 32'(out_sof), 32'(exp_q[0].sof));
                checkOutput("out_eol", 32'(out_eol), 32'(exp_q[0].eol));
                checkOutput("out_hsv", 32'(out_hsv), 32'(exp_q[0].hsv));
            end
            checkOutput("err_ovf", 32'(err_ovf), 0);
            acc0 = in0_valid && in0_ready;
            acc1 = in1_valid && in1_ready;
            if (in1_ready) in1_ready_hi++;
            if (hv && out_ready) void'(exp_q.pop_front());
            if (e0 || e1) begin
                it.t   = cyc + 1;
                it.src = gs;
                it.sof = gs ? in1_sof : in0_sof;
                it.eol = gs ? in1_eol : in0_eol;
                it.hsv = hsv_of(gs ? in1_rgb : in0_rgb);
                exp_q.push_back(it);
                m_rgb  = gs ? in1_rgb : in0_rgb;
                m_last = gs;
                last_issue_t = cyc + 1;
                n_issue++;
                if (gs) grants1++;
                else grants0++;
            end
        end
    end

    // Random sources: a pixel is held until accepted, then replaced per the valid probability.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_in) begin
            if (!in0_valid || acc0) begin
                in0_valid = ($urandom_range(99) < p0);
                in0_rgb   = 24'($urandom);
                in0_sof   = 1'($urandom_range(1));
                in0_eol   = 1'($urandom_range(1));
            end
            if (!in1_valid || acc1) begin
                in1_valid = ($urandom_range(99) < p1);
                in1_rgb   = 24'($urandom);
                in1_sof   = 1'($urandom_range(1));
                in1_eol   = 1'($urandom_range(1));
            end
        end
        if (auto_rdy) out_ready = ($urandom_range(99) < rdy_pct);
    end

    task automatic applyStimulus(input int v0, input int v1, input int rp, input logic pm);
        @(posedge clk);
        #2;
        p0 = v0;
        p1 = v1;
        rdy_pct = rp;
        prio_mode = pm;
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit done;
        reset_b = 1'b0;
        prio_mode = 1'b0;
        in0_valid = 0; in0_rgb = 0; in0_sof = 0; in0_eol = 0;
        in1_valid = 0; in1_rgb = 0; in1_sof = 0; in1_eol = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_b = 1'b1;
        repeat (3) @(posedge clk);

        // Hand-computed pins of the reference conversion.
        checkOutput("pin_red",   32'(hsv_of(24'hFF0000)), 32'h007FFFF);
        checkOutput("pin_green", 32'(hsv_of(24'h00FF00)), 32'h3C7FFFF);
        checkOutput("pin_gray",  32'(hsv_of(24'h808080)), 32'h0000080);

        // First pixel: pure red with sof on ch0.
        #2;
        in0_valid = 1'b1; in0_rgb = 24'hFF0000; in0_sof = 1'b1; in0_eol = 1'b0;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            done = in0_ready;
        end
        checkOutput("first_accept", 32'(done), 1);
        @(posedge clk);
        #2 in0_valid = 1'b0; in0_sof = 1'b0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            done = out_valid;
        end
        checkOutput("first_out_valid", 32'(done), 1);
        checkOutput("first_latency", 32'(cyc - last_issue_t), PIPE_LAT);
        checkOutput("first_hsv", 32'(out_hsv), 32'h007FFFF);
        checkOutput("first_src", 32'(out_src), 0);
        checkOutput("first_sof", 32'(out_sof), 1);
        repeat (3) @(posedge clk);

        // Round-robin with both channels saturated: exact alternation, no bubbles.
        auto_in = 1; auto_rdy = 1;
        applyStimulus(100, 100, 100, 1'b0);
        repeat (30) @(posedge clk);
        #2 grants0 = 0; grants1 = 0; n_issue = 0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2;
        checkOutput("rr_issues", 32'(n_issue), 40);
        checkOutput("rr_grants0", 32'(grants0), 20);
        checkOutput("rr_grants1", 32'(grants1), 20);

        // Strict priority: ch0 takes every slot for 10 cycles.
        prio_mode = 1'b1;
        grants0 = 0; grants1 = 0; in1_ready_hi = 0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        checkOutput("prio_grants0", 32'(grants0), 10);
        checkOutput("prio_grants1", 32'(grants1), 0);
        checkOutput("prio_in1_ready", 32'(in1_ready_hi), 0);

        // Drain, then stall the output: exactly FIFO_DEPTH pixels accepted.
        applyStimulus(0, 0, 100, 1'b0);
        repeat (50) @(posedge clk);
        #2 auto_rdy = 0; out_ready = 1'b0; n_issue = 0;
        applyStimulus(100, 100, 0, 1'b0);
        repeat (70) @(posedge clk);
        #3;
        checkOutput("full_issues", 32'(n_issue), FIFO_DEPTH);
        checkOutput("full_ready", {30'd0, in0_ready, in1_ready}, 0);
        checkOutput("full_out_valid", 32'(out_valid), 1);

        // One-cycle pop frees exactly one credit.
        @(posedge clk);
        #2 out_ready = 1'b1; n_issue = 0;
        @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pulse_issues", 32'(n_issue), 1);

        // Release the output and drain in issue order.
        auto_rdy = 1;
        applyStimulus(0, 0, 100, 1'b0);
        repeat (70) @(posedge clk);

        // Reset with pixels in flight: nothing stale may emerge afterwards.
        #2 auto_in = 0;
        in0_valid = 0; in1_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2 in0_valid = 1'b1; in0_rgb = 24'($urandom); in0_sof = 1'($urandom_range(1));
        end
        @(posedge clk);
        #2 in0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_b = 1'b1;
        stale = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rst_no_stale", 32'(stale), 0);

        // Random traffic, backpressure and mode changes.
        auto_in = 1;
        for (int blk = 0; blk < 40; blk++) begin
            applyStimulus($urandom_range(100), $urandom_range(100), $urandom_range(100),
                          1'($urandom_range(1)));
            repeat (50) @(posedge clk);
        end
        applyStimulus(0, 0, 100, 1'b0);
        repeat (80) @(posedge clk);
        checkOutput("end_model_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
